// File: rtl/uart_capture_pkg.sv
// Shared types and helpers for the UART TX snoop/capture stage.
package uart_capture_pkg;

    typedef enum logic {
        CAP_GATHER = 1'b0,
        CAP_DRAIN  = 1'b1
    } cap_state_t;

    localparam logic [7:0] ASCII_LF = 8'h0a;

    // Picks the byte on the lowest strobed lane; lane 0 if no strobe is set.
    function automatic logic [7:0] lane_byte(input logic [3:0] we, input logic [31:0] wdata);
        logic [7:0] b;
        b = wdata[7:0];
        if (we[0])      b = wdata[7:0];
        else if (we[1]) b = wdata[15:8];
        else if (we[2]) b = wdata[23:16];
        else if (we[3]) b = wdata[31:24];
        return b;
    endfunction

endpackage

// File: rtl/uart_capture_if.sv
// Core bus snoop inputs plus the byte stream and statistics toward the consumer.
interface uart_capture_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_we;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        byte_eol;
    logic [15:0] drop_cnt;
    logic [15:0] line_cnt;

    modport master (
        output bus_addr, bus_wdata, bus_we, byte_ready,
        input  byte_valid, byte_data, byte_eol, drop_cnt, line_cnt
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, byte_ready,
        output byte_valid, byte_data, byte_eol, drop_cnt, line_cnt
    );
endinterface

// File: rtl/uart_capture_sync_fifo.sv
// Single-clock FIFO; caller guarantees no push when full (unless popping) and no pop when empty.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
endmodule

// File: rtl/uart_capture.sv
// Captures CPU writes to the debug UART TX register and hands bytes to a consumer, optionally per line.
//   state      | meaning
//   CAP_GATHER | collecting bytes, output held back
//   CAP_DRAIN  | releasing buffered bytes to the consumer
module uart_capture
    import uart_capture_pkg::*;
#(
    parameter logic [31:0] UART_ADDR = 32'hf00000d0,
    parameter int          DEPTH     = 16,
    parameter bit          LINE_MODE = 1'b1,
    parameter int          TIMEOUT   = 256
) (
    input logic           clk,
    input logic           reset,
    uart_capture_if.slave port
);
    localparam int              CW          = $clog2(DEPTH) + 1;
    localparam int              IW          = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   FULL_CNT    = CW'(DEPTH);
    localparam logic [IW-1:0]   IDLE_LAST   = IW'(TIMEOUT - 1);
    localparam logic [31:0]     ADDR_MASK   = 32'hffff_fffc;
    localparam cap_state_t      RESET_STATE = LINE_MODE ? CAP_GATHER : CAP_DRAIN;

    cap_state_t    state;
    logic [IW-1:0] idle_cnt;
    logic [CW-1:0] count, count_next, pend_eol, pend_next;
    logic [15:0]   drop_cnt, line_cnt;
    logic [8:0]    head;
    logic [7:0]    in_byte;
    logic          full, empty, hit, push, pop, drop, in_eol, head_eol, valid;

    assign hit      = (port.bus_we != 4'b0) && (((port.bus_addr ^ UART_ADDR) & ADDR_MASK) == '0);
    assign in_byte  = lane_byte(port.bus_we, port.bus_wdata);
    assign in_eol   = (in_byte == ASCII_LF);
    assign valid    = (state == CAP_DRAIN) && !empty;
    assign pop      = valid && port.byte_ready;
    assign push     = hit && (!full || pop);
    assign drop     = hit && full && !pop;
    assign head_eol = !empty && head[8];

    sync_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({in_eol, in_byte}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (pop && !push) count_next = count - 1'b1;
        pend_next = pend_eol;
        if ((push && in_eol) && !(pop && head_eol))      pend_next = pend_eol + 1'b1;
        else if (!(push && in_eol) && (pop && head_eol)) pend_next = pend_eol - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RESET_STATE;
            idle_cnt <= '0;
            pend_eol <= '0;
            drop_cnt <= '0;
            line_cnt <= '0;
        end else begin
            pend_eol <= pend_next;
            if (drop && drop_cnt != 16'hffff) drop_cnt <= drop_cnt + 1'b1;
            if (pop && head_eol)              line_cnt <= line_cnt + 1'b1;
            // Idle count saturates so a long quiet spell cannot wrap past the timeout.
            if (state == CAP_DRAIN || hit)   idle_cnt <= '0;
            else if (idle_cnt != IDLE_LAST)  idle_cnt <= idle_cnt + 1'b1;
            if (LINE_MODE) begin
                case (state)
                    CAP_GATHER:
                        if ((push && in_eol) || count_next == FULL_CNT ||
                            (idle_cnt == IDLE_LAST && !empty))
                            state <= CAP_DRAIN;
                    CAP_DRAIN:
                        if (((pop && head_eol) || count_next == '0) && pend_next == '0)
                            state <= CAP_GATHER;
                    default: state <= RESET_STATE;
                endcase
            end else begin
                state <= CAP_DRAIN;
            end
        end
    end

    assign port.byte_valid = valid;
    assign port.byte_data  = empty ? 8'h00 : head[7:0];
    assign port.byte_eol   = head_eol;
    assign port.drop_cnt   = drop_cnt;
    assign port.line_cnt   = line_cnt;
endmodule

// File: tb/tb_uart_capture.sv
// Bench for uart_capture: one byte-mode and one line-mode instance, scoreboarded byte streams.
module tb_uart_capture;
    import uart_capture_pkg::*;

    localparam logic [31:0] UART_A = 32'hf00000d0;

    logic        clk, reset;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [3:0]  we0, we1;
    logic        rdy0, rdy1;
    int          n_tests, n_fail, n_pop0, n_pop1, wait_k, base;
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [8:0]  exp0, exp1;

    uart_capture_if if0();
    uart_capture_if if1();

    assign if0.bus_addr   = addr0;
    assign if0.bus_wdata  = wdata0;
    assign if0.bus_we     = we0;
    assign if0.byte_ready = rdy0;
    assign if1.bus_addr   = addr1;
    assign if1.bus_wdata  = wdata1;
    assign if1.bus_we     = we1;
    assign if1.byte_ready = rdy1;

    uart_capture #(.LINE_MODE(1'b0)) u_dut0 (.clk(clk), .reset(reset), .port(if0));
    uart_capture #(.LINE_MODE(1'b1)) u_dut1 (.clk(clk), .reset(reset), .port(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cpu_write(input int sel, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] we);
        if (sel == 0) begin addr0 = addr; wdata0 = data; we0 = we; end
        else          begin addr1 = addr; wdata1 = data; we1 = we; end
        @(posedge clk); #1;
        we0 = 4'b0;
        we1 = 4'b0;
    endtask

    // Handshakes seen at negedge complete on the following rising edge.
    always @(negedge clk) begin
        if (!reset && if0.byte_valid && rdy0) begin
            n_pop0++;
            if (q0.size() == 0) check_val("sb0_extra", 32'(q0.size()), 32'd1);
            else begin
                exp0 = q0.pop_front();
                check_val("sb0_byte", {23'b0, if0.byte_eol, if0.byte_data}, {23'b0, exp0});
            end
        end
        if (!reset && if1.byte_valid && rdy1) begin
            n_pop1++;
            if (q1.size() == 0) check_val("sb1_extra", 32'(q1.size()), 32'd1);
            else begin
                exp1 = q1.pop_front();
                check_val("sb1_byte", {23'b0, if1.byte_eol, if1.byte_data}, {23'b0, exp1});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; n_pop0 = 0; n_pop1 = 0;
        addr0 = '0; wdata0 = '0; we0 = '0; rdy0 = 1'b0;
        addr1 = '0; wdata1 = '0; we1 = '0; rdy1 = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid0", {31'b0, if0.byte_valid}, 0);
        check_val("rst_valid1", {31'b0, if1.byte_valid}, 0);
        check_val("rst_data0", 32'(if0.byte_data), 0);
        check_val("rst_drop0", 32'(if0.drop_cnt), 0);
        check_val("rst_line1", 32'(if1.line_cnt), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // byte mode: single write, wrong address, no strobe, lane select
        rdy0 = 1'b1;
        base = n_pop0;
        q0.push_back({1'b0, 8'h48});
        cpu_write(0, UART_A, 32'h00000048, 4'b0001);
        check_val("t1_valid", {31'b0, if0.byte_valid}, 1);
        check_val("t1_data", 32'(if0.byte_data), 32'h48);
        @(posedge clk); #1;
        check_val("t1_popped", n_pop0 - base, 1);
        check_val("t1_empty", {31'b0, if0.byte_valid}, 0);
        cpu_write(0, 32'hf00000d4, 32'h00000048, 4'b0001);
        check_val("t1_wrong_addr", {31'b0, if0.byte_valid}, 0);
        cpu_write(0, UART_A, 32'h00000048, 4'b0000);
        check_val("t1_no_strobe", {31'b0, if0.byte_valid}, 0);
        q0.push_back({1'b0, 8'h33});
        cpu_write(0, UART_A + 32'd2, 32'h11223344, 4'b1010);
        check_val("t1_lane1", 32'(if0.byte_data), 32'h33);
        @(posedge clk); #1;
        check_val("t1_pops", n_pop0 - base, 2);

        // line mode: H i LF on lane 2
        rdy1 = 1'b1;
        q1.push_back({1'b0, 8'h48});
        cpu_write(1, UART_A, 32'h00480000, 4'b0100);
        check_val("t2_hold_h", {31'b0, if1.byte_valid}, 0);
        q1.push_back({1'b0, 8'h69});
        cpu_write(1, UART_A, 32'h00690000, 4'b0100);
        check_val("t2_hold_i", {31'b0, if1.byte_valid}, 0);
        q1.push_back({1'b1, 8'h0a});
        cpu_write(1, UART_A, 32'h000a0000, 4'b0100);
        check_val("t2_release", {31'b0, if1.byte_valid}, 1);
        check_val("t2_head", 32'(if1.byte_data), 32'h48);
        for (int k = 0; k < 10 && q1.size() != 0; k++) begin @(posedge clk); #1; end
        check_val("t2_drained", 32'(q1.size()), 0);
        check_val("t2_line_cnt", 32'(if1.line_cnt), 1);
        check_val("t2_state", 32'(u_dut1.state), 32'(CAP_GATHER));
        check_val("t2_valid_off", {31'b0, if1.byte_valid}, 0);

        // overflow: 20 writes into 16 entries
        rdy0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) q0.push_back({1'b0, 8'(8'h30 + i)});
            cpu_write(0, UART_A, 32'(8'h30 + i), 4'b0001);
        end
        check_val("t3_drop", 32'(if0.drop_cnt), 4);
        check_val("t3_count", 32'(u_dut0.u_fifo.count), 16);
        check_val("t3_head", 32'(if0.byte_data), 32'h30);

        // full with simultaneous pop and hit
        base = n_pop0;
        rdy0 = 1'b1;
        q0.push_back({1'b0, 8'h60});
        cpu_write(0, UART_A, 32'h00000060, 4'b0001);
        check_val("t4_drop", 32'(if0.drop_cnt), 4);
        check_val("t4_count", 32'(u_dut0.u_fifo.count), 16);
        for (int k = 0; k < 40 && q0.size() != 0; k++) begin @(posedge clk); #1; end
        check_val("t3_drained", 32'(q0.size()), 0);
        check_val("t3_pops", n_pop0 - base, 17);
        check_val("t3_valid_off", {31'b0, if0.byte_valid}, 0);

        // line mode timeout on a partial line
        q1.push_back({1'b0, 8'h41});
        cpu_write(1, UART_A, 32'h00000041, 4'b0001);
        wait_k = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (if1.byte_valid) begin
                wait_k = k;
                break;
            end
        end
        check_val("t5_latency", wait_k, 256);
        check_val("t5_data", 32'(if1.byte_data), 32'h41);
        @(posedge clk); #1;
        check_val("t5_drained", 32'(q1.size()), 0);
        check_val("t5_state", 32'(u_dut1.state), 32'(CAP_GATHER));
        check_val("t5_valid_off", {31'b0, if1.byte_valid}, 0);

        // mid-operation reset
        rdy0 = 1'b0;
        q0.push_back({1'b0, 8'h61});
        cpu_write(0, UART_A, 32'h00000061, 4'b0001);
        q0.push_back({1'b1, 8'h0a});
        cpu_write(0, UART_A, 32'h0000000a, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            q0.push_back({1'b0, 8'(8'h62 + i)});
            cpu_write(0, UART_A, 32'(8'h62 + i), 4'b0001);
        end
        rdy0 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rdy0 = 1'b0;
        check_val("t6_line_pre", 32'(if0.line_cnt), 1);
        check_val("t6_left", 32'(q0.size()), 3);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        cpu_write(0, UART_A, 32'h00000051, 4'b0001);
        check_val("t6_valid", {31'b0, if0.byte_valid}, 0);
        check_val("t6_drop", 32'(if0.drop_cnt), 0);
        check_val("t6_line", 32'(if0.line_cnt), 0);
        check_val("t6_count", 32'(u_dut0.u_fifo.count), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("t6_rst_hit", {31'b0, if0.byte_valid}, 0);
        base = n_pop0;
        rdy0 = 1'b1;
        q0.push_back({1'b0, 8'h5a});
        cpu_write(0, UART_A, 32'h0000005a, 4'b0001);
        check_val("t6_new_data", 32'(if0.byte_data), 32'h5a);
        repeat (3) begin @(posedge clk); #1; end
        check_val("t6_only_one", n_pop0 - base, 1);
        check_val("t6_valid_off", {31'b0, if0.byte_valid}, 0);
        check_val("end_q0", 32'(q0.size()), 0);
        check_val("end_q1", 32'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
